// File: rtl/bus_dma.sv
// Block-copy bus initiator: reads a word from src, writes it to dst, repeats count times.
// All outputs are registered; the FSM computes next-cycle bus values on each transition.
module bus_dma #(
  parameter int COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_in,
  input  logic [31:0]           src_addr_in,
  input  logic [31:0]           dst_addr_in,
  input  logic [COUNT_BITS-1:0] count_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [COUNT_BITS-1:0] remaining_out,
  output logic [31:0]           address_out,
  output logic                  sel_out,
  output logic                  read_out,
  output logic [3:0]            write_mask_out,
  output logic [31:0]           write_value_out,
  input  logic [31:0]           read_value_in,
  input  logic                  ready_in
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state;
  logic [31:0]           src;
  logic [31:0]           dst;
  logic [COUNT_BITS-1:0] remaining;

  assign remaining_out = remaining;

  // Bus handshake: a transaction is offered while sel_out is high and completes in
  // the cycle ready_in is high; all request fields stay frozen until that cycle.
  // write_value_out doubles as the data register holding the word being moved.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      src             <= '0;
      dst             <= '0;
      remaining       <= '0;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
      sel_out         <= 1'b0;
      read_out        <= 1'b0;
      write_mask_out  <= '0;
      address_out     <= '0;
      write_value_out <= '0;
    end else begin
      done_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_in) begin
            if (count_in != '0) begin
              src         <= {src_addr_in[31:2], 2'b00};
              dst         <= {dst_addr_in[31:2], 2'b00};
              remaining   <= count_in;
              state       <= READ;
              busy_out    <= 1'b1;
              sel_out     <= 1'b1;
              read_out    <= 1'b1;
              address_out <= {src_addr_in[31:2], 2'b00};
            end else begin
              state    <= DONE;
              done_out <= 1'b1;
            end
          end
        end
        READ: begin
          if (ready_in) begin
            state           <= WRITE;
            write_value_out <= read_value_in;
            read_out        <= 1'b0;
            write_mask_out  <= 4'b1111;
            address_out     <= dst;
          end
        end
        WRITE: begin
          if (ready_in) begin
            src             <= src + 32'd4;
            dst             <= dst + 32'd4;
            remaining       <= remaining - COUNT_BITS'(1);
            write_mask_out  <= '0;
            write_value_out <= '0;
            if (remaining == COUNT_BITS'(1)) begin
              state       <= DONE;
              done_out    <= 1'b1;
              busy_out    <= 1'b0;
              sel_out     <= 1'b0;
              address_out <= '0;
            end else begin
              state       <= READ;
              read_out    <= 1'b1;
              address_out <= src + 32'd4;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dma.sv
// Bench for bus_dma: RAM responder with programmable wait states, vector table of
// copies checked cycle by cycle, plus a hand-written reset-abort sequence.
module tb_bus_dma;
  localparam int CB = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_in;
  logic [31:0]   src_addr_in;
  logic [31:0]   dst_addr_in;
  logic [CB-1:0] count_in;
  logic          busy_out;
  logic          done_out;
  logic [CB-1:0] remaining_out;
  logic [31:0]   address_out;
  logic          sel_out;
  logic          read_out;
  logic [3:0]    write_mask_out;
  logic [31:0]   write_value_out;
  logic [31:0]   read_value_in;
  logic          ready_in;

  bus_dma #(.COUNT_BITS(CB)) dut (
    .clk(clk), .reset(reset), .start_in(start_in),
    .src_addr_in(src_addr_in), .dst_addr_in(dst_addr_in), .count_in(count_in),
    .busy_out(busy_out), .done_out(done_out), .remaining_out(remaining_out),
    .address_out(address_out), .sel_out(sel_out), .read_out(read_out),
    .write_mask_out(write_mask_out), .write_value_out(write_value_out),
    .read_value_in(read_value_in), .ready_in(ready_in)
  );

  always #5 clk = ~clk;

  // ---------------- RAM responder ----------------
  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic [31:0] data;
  } txn_t;

  txn_t        log_q[$];
  logic [31:0] mem   [logic [31:0]];
  logic [31:0] model [logic [31:0]];
  int          wait_cnt = 0;
  int          period = 1;
  logic        stall = 1'b0;

  function automatic logic [31:0] ram_init(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 32'd11;
      32'h0000_1004: return 32'd22;
      32'h0000_1008: return 32'd33;
      32'h0000_100C: return 32'd44;
      default:       return a ^ 32'hC0DE_0000;
    endcase
  endfunction

  assign ready_in = sel_out && !stall && (wait_cnt == period - 1);

  always @(negedge clk)
    read_value_in = mem.exists(address_out) ? mem[address_out] : ram_init(address_out);

  always @(posedge clk) begin
    if (!reset && sel_out && ready_in) begin
      log_q.push_back('{address_out, read_out, read_out ? read_value_in : write_value_out});
      if (write_mask_out != 4'b0000) mem[address_out] = write_value_out;
    end
    if (reset || !sel_out || ready_in) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  // ---------------- scoreboard helpers ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0]   src;
    logic [31:0]   dst;
    logic [CB-1:0] cnt;
    int            per;
    int            done_cyc;
    int            ign_cyc;
  } vec_t;

  vec_t vt[8];

  task automatic run_xfer(input vec_t v);
    int          base;
    int          done_c;
    int          wr_before;
    logic        p_wait;
    logic [31:0] p_addr;
    logic [31:0] p_ctl;
    logic [31:0] sa, da, ra, wa, d;
    base   = log_q.size();
    period = v.per;
    @(negedge clk);
    src_addr_in = v.src;
    dst_addr_in = v.dst;
    count_in    = v.cnt;
    start_in    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    done_c = -1;
    p_wait = 1'b0;
    p_addr = '0;
    p_ctl  = '0;
    for (int c = 1; c <= 200; c++) begin
      start_in = (c == v.ign_cyc);
      if (c == v.ign_cyc) begin
        src_addr_in = 32'h0000_7000;
        count_in    = CB'(5);
      end
      wr_before = (c - 1) / (2 * v.per);
      chk("busy", 32'(busy_out), 32'(c < v.done_cyc));
      chk("sel", 32'(sel_out), 32'(c < v.done_cyc));
      chk("remaining", 32'(remaining_out), 32'(int'(v.cnt) - wr_before));
      if (!sel_out)
        chk("idle_bus", address_out | write_value_out | {27'b0, read_out, write_mask_out}, 32'h0);
      if (p_wait) begin
        chk("hold_addr", address_out, p_addr);
        chk("hold_ctl", write_value_out ^ {27'b0, read_out, write_mask_out}, p_ctl);
      end
      if (done_out) begin
        done_c = c;
        break;
      end
      p_wait = sel_out && !ready_in;
      p_addr = address_out;
      p_ctl  = write_value_out ^ {27'b0, read_out, write_mask_out};
      @(posedge clk);
      @(negedge clk);
    end
    chk("done_cycle", 32'(done_c), 32'(v.done_cyc));
    start_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_done", {29'b0, done_out, sel_out, busy_out}, 32'h0);
    chk("txn_count", 32'(log_q.size() - base), 32'(2 * int'(v.cnt)));
    sa = v.src & 32'hFFFF_FFFC;
    da = v.dst & 32'hFFFF_FFFC;
    for (int k = 0; k < int'(v.cnt); k++) begin
      ra = sa + 32'(4 * k);
      wa = da + 32'(4 * k);
      d  = model.exists(ra) ? model[ra] : ram_init(ra);
      model[wa] = d;
      if (base + 2 * k + 1 < log_q.size()) begin
        chk("rd_addr", log_q[base + 2 * k].addr, ra);
        chk("rd_kind", 32'(log_q[base + 2 * k].rd), 32'h1);
        chk("rd_data", log_q[base + 2 * k].data, d);
        chk("wr_addr", log_q[base + 2 * k + 1].addr, wa);
        chk("wr_kind", 32'(log_q[base + 2 * k + 1].rd), 32'h0);
        chk("wr_data", log_q[base + 2 * k + 1].data, d);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    //        src            dst            cnt  per done ign
    vt[0] = '{32'h0000_1000, 32'h0000_2000, 16'd4, 1,  9,  0};  // basic copy
    vt[1] = '{32'h0000_1000, 32'h0000_3000, 16'd2, 3, 13,  0};  // ready every 3rd sel cycle
    vt[2] = '{32'h0000_1000, 32'h0000_2000, 16'd0, 1,  1,  0};  // zero count
    vt[3] = '{32'h0000_1003, 32'h0000_2002, 16'd1, 1,  3,  0};  // unaligned addresses
    vt[4] = '{32'hFFFF_FFFC, 32'h0000_4000, 16'd2, 1,  5,  1};  // wrap, start during READ
    vt[5] = '{32'h0000_5000, 32'h0000_5004, 16'd3, 2, 13,  0};  // overlapping ranges
    vt[6] = '{32'h0000_1000, 32'h0000_8000, 16'd1, 1,  3,  3};  // start during DONE
    vt[7] = '{32'h0000_1004, 32'h0000_9000, 16'd3, 1,  7,  0};  // follow-up after reset

    reset       = 1'b1;
    start_in    = 1'b0;
    src_addr_in = '0;
    dst_addr_in = '0;
    count_in    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy_out), 32'h0);
    chk("rst_done", 32'(done_out), 32'h0);
    chk("rst_remaining", 32'(remaining_out), 32'h0);
    chk("rst_addr", address_out, 32'h0);
    chk("rst_sel", 32'(sel_out), 32'h0);
    chk("rst_read", 32'(read_out), 32'h0);
    chk("rst_mask", 32'(write_mask_out), 32'h0);
    chk("rst_wval", write_value_out, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_xfer(vt[i]);

    // Reset while a write is stalled: abort with no done pulse.
    period = 1;
    @(negedge clk);
    src_addr_in = 32'h0000_1000;
    dst_addr_in = 32'h0000_6000;
    count_in    = CB'(3);
    start_in    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_in = 1'b0;
    chk("abort_read_phase", 32'(sel_out & read_out), 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("abort_write_phase", 32'(write_mask_out), 32'hF);
    stall = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_sel", 32'(sel_out), 32'h0);
    chk("abort_busy", 32'(busy_out), 32'h0);
    chk("abort_done", 32'(done_out), 32'h0);
    chk("abort_remaining", 32'(remaining_out), 32'h0);
    chk("abort_bus", address_out | write_value_out | {27'b0, read_out, write_mask_out}, 32'h0);
    reset = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("abort_quiet", {30'b0, done_out, sel_out}, 32'h0);
    end
    chk("abort_no_write", 32'(mem.exists(32'h0000_6000)), 32'h0);

    run_xfer(vt[7]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
